data_upload: RTL and testbench

DATA_UPLOAD -- requirements
Module: data_upload

---
 rtl/data_upload.sv | 118 +++++++++++
 tb/tb_data_upload.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_upload.sv
// data_upload: SPI slave that streams RAM bytes to the IO controller during an upload session.
// One byte is prefetched into a buffer so each SPI byte slot can be served without waiting on RAM.
module data_upload #(
    parameter logic [7:0] CMD_INDEX  = 8'h55,
    parameter logic [7:0] CMD_RX     = 8'h56,
    parameter logic [7:0] CMD_RX_DAT = 8'h57
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sck,
    input  logic        ss,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_oe,
    output logic        uploading,
    output logic        underrun,
    output logic [4:0]  index,
    output logic        rd_req,
    input  logic        rd_ack,
    output logic [24:0] addr,
    input  logic [7:0]  din,
    output logic [24:0] byte_cnt
);
    logic [1:0]  sck_sy, ss_sy, sdi_sy;
    logic        sck_prev, buf_valid;
    logic [3:0]  cnt;
    logic [7:0]  cmd, buffer, shreg, rx_byte;
    logic [6:0]  sbuf;
    logic        sck_q, ss_q, sdi_q, rise, fall, start, stop, load;
    logic [24:0] base;

    always_comb begin
        sck_q   = sck_sy[1];
        ss_q    = ss_sy[1];
        sdi_q   = sdi_sy[1];
        rise    = !ss_q && sck_q && !sck_prev;
        fall    = !ss_q && !sck_q && sck_prev;
        rx_byte = {sbuf, sdi_q};
        start   = rise && cnt == 4'd15 && cmd == CMD_RX && sdi_q;
        stop    = rise && cnt == 4'd15 && cmd == CMD_RX && !sdi_q;
        load    = uploading && rise && ((cnt == 4'd7 && rx_byte == CMD_RX_DAT) ||
                                        (cnt == 4'd15 && cmd == CMD_RX_DAT));
        base    = index == 5'd1 ? 25'h200000 :
                  (index == 5'd2 || index == 5'd3) ? 25'h400000 : 25'h170000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sy    <= 2'b00;
            ss_sy     <= 2'b11;
            sdi_sy    <= 2'b00;
            sck_prev  <= 1'b0;
            cnt       <= 4'd0;
            cmd       <= 8'd0;
            sbuf      <= 7'd0;
            buffer    <= 8'd0;
            buf_valid <= 1'b0;
            shreg     <= 8'd0;
            sdo       <= 1'b0;
            sdo_oe    <= 1'b0;
            uploading <= 1'b0;
            underrun  <= 1'b0;
            index     <= 5'd0;
            rd_req    <= 1'b0;
            addr      <= 25'd0;
            byte_cnt  <= 25'd0;
        end else begin
            sck_sy   <= {sck_sy[0], sck};
            ss_sy    <= {ss_sy[0], ss};
            sdi_sy   <= {sdi_sy[0], sdi};
            sck_prev <= sck_q;
            // A read completing after (or as) the session stops is consumed but its data dropped
            if (rd_req && rd_ack) begin
                rd_req <= 1'b0;
                if (uploading && !stop) begin
                    buffer    <= din;
                    buf_valid <= 1'b1;
                    addr      <= addr + 25'd1;
                end
            end
            if (ss_q) begin
                cnt    <= 4'd0;
                sdo_oe <= 1'b0;
            end
            if (rise) begin
                sbuf <= rx_byte[6:0];
                cnt  <= cnt == 4'd15 ? 4'd8 : cnt + 4'd1;
                if (cnt == 4'd7) cmd <= rx_byte;
                if (cnt == 4'd15 && cmd == CMD_INDEX) index <= rx_byte[4:0];
            end
            if (fall) begin
                sdo   <= shreg[7];
                shreg <= {shreg[6:0], 1'b0};
            end
            if (stop) uploading <= 1'b0;
            if (start) begin
                addr      <= base;
                byte_cnt  <= 25'd0;
                underrun  <= 1'b0;
                buf_valid <= 1'b0;
                uploading <= 1'b1;
                rd_req    <= 1'b1;
            end
            if (load) begin
                sdo_oe <= 1'b1;
                if (buf_valid) begin
                    shreg     <= buffer;
                    buf_valid <= 1'b0;
                    byte_cnt  <= byte_cnt + 25'd1;
                    rd_req    <= 1'b1;
                end else begin
                    shreg    <= 8'hFF;
                    underrun <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_upload.sv
// tb_data_upload: directed scenarios driving the SPI side as master and modelling the RAM.
module tb_data_upload;
    logic        clk = 1'b0, reset_n = 1'b0, sck = 1'b0, ss = 1'b1, sdi = 1'b0;
    logic        sdo, sdo_oe, uploading, underrun, rd_req, rd_ack;
    logic [4:0]  index;
    logic [24:0] addr, byte_cnt;
    logic [7:0]  din;
    logic        a_ack = 1'b0, m_ack = 1'b0;
    logic [7:0]  a_din = 8'd0, m_din = 8'd0;
    logic [7:0]  ram [0:15];
    bit          ram_auto = 1'b1;
    int          ram_lat = 1;
    int          n_chk = 0, n_fail = 0;
    int          H = 8;

    assign rd_ack = a_ack | m_ack;
    assign din    = m_ack ? m_din : a_din;

    data_upload dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .uploading(uploading), .underrun(underrun),
        .index(index), .rd_req(rd_req), .rd_ack(rd_ack), .addr(addr),
        .din(din), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    // RAM: answers a pending request ram_lat cycles later with the byte at the low address bits
    initial forever begin
        @(negedge clk);
        if (ram_auto && rd_req) begin
            repeat (ram_lat - 1) @(negedge clk);
            a_din = ram[addr[3:0]];
            a_ack = 1'b1;
            @(negedge clk);
            a_ack = 1'b0;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nrise, output logic [7:0] rx);
        for (int k = 0; k < 8; k++) begin
            sdi = tx[7-k];
            wait_clk(H);
            rx[7-k] = sdo;
            if (k < nrise) begin
                sck = 1'b1;
                wait_clk(H);
                sck = 1'b0;
            end
        end
    endtask

    task automatic ss_low();
        ss = 1'b0;
        wait_clk(H);
    endtask

    task automatic ss_high();
        wait_clk(H);
        ss = 1'b1;
        wait_clk(4 * H);
    endtask

    task automatic test_reset();
        wait_clk(3);
        n_chk++;
        if ({rd_req, sdo, sdo_oe, uploading, underrun} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000", {rd_req, sdo, sdo_oe, uploading, underrun});
        end
        n_chk++;
        if ({index, addr, byte_cnt} !== 55'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got index=%h addr=%h byte_cnt=%h expected 0", index, addr, byte_cnt);
        end
        reset_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_index_start();
        logic [7:0] rx;
        ss_low(); xfer(8'h55, 8, rx); xfer(8'h02, 8, rx); ss_high();
        n_chk++;
        if (index !== 5'd2) begin n_fail++; $display("FAIL index: got %h expected 02", index); end
        n_chk++;
        if (uploading !== 1'b0) begin n_fail++; $display("FAIL idle_uploading: got %b expected 0", uploading); end
        ss_low(); xfer(8'h56, 8, rx); xfer(8'h01, 8, rx); ss_high();
        n_chk++;
        if (uploading !== 1'b1) begin n_fail++; $display("FAIL start_uploading: got %b expected 1", uploading); end
        n_chk++;
        if (addr !== 25'h400001) begin n_fail++; $display("FAIL start_addr: got %h expected 400001", addr); end
        n_chk++;
        if (rd_req !== 1'b0) begin n_fail++; $display("FAIL start_rd_req: got %b expected 0", rd_req); end
    endtask

    task automatic test_data_read();
        logic [7:0] rx, r1, r2, r3;
        ss_low(); xfer(8'h57, 8, rx); xfer(8'h00, 8, r1); xfer(8'h00, 8, r2); xfer(8'h00, 7, r3);
        n_chk++;
        if (sdo_oe !== 1'b1) begin n_fail++; $display("FAIL read_sdo_oe: got %b expected 1", sdo_oe); end
        ss_high();
        n_chk++;
        if (r1 !== 8'hA5) begin n_fail++; $display("FAIL read_byte1: got %h expected a5", r1); end
        n_chk++;
        if (r2 !== 8'h5A) begin n_fail++; $display("FAIL read_byte2: got %h expected 5a", r2); end
        n_chk++;
        if (r3 !== 8'h3C) begin n_fail++; $display("FAIL read_byte3: got %h expected 3c", r3); end
        n_chk++;
        if (byte_cnt !== 25'd3) begin n_fail++; $display("FAIL read_byte_cnt: got %0d expected 3", byte_cnt); end
        n_chk++;
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL read_underrun: got %b expected 0", underrun); end
        n_chk++;
        if (sdo_oe !== 1'b0) begin n_fail++; $display("FAIL deselect_sdo_oe: got %b expected 0", sdo_oe); end
        n_chk++;
        if (addr !== 25'h400004) begin n_fail++; $display("FAIL read_addr: got %h expected 400004", addr); end
    endtask

    task automatic test_underrun();
        logic [7:0] rx, r1, r2;
        ram_lat = 400;
        ss_low(); xfer(8'h57, 8, rx); xfer(8'h00, 8, r1); xfer(8'h00, 7, r2); ss_high();
        n_chk++;
        if (r1 !== 8'hC3) begin n_fail++; $display("FAIL under_byte1: got %h expected c3", r1); end
        n_chk++;
        if (r2 !== 8'hFF) begin n_fail++; $display("FAIL under_byte2: got %h expected ff", r2); end
        n_chk++;
        if (underrun !== 1'b1) begin n_fail++; $display("FAIL under_flag: got %b expected 1", underrun); end
        n_chk++;
        if (byte_cnt !== 25'd4) begin n_fail++; $display("FAIL under_byte_cnt: got %0d expected 4", byte_cnt); end
        n_chk++;
        if (rd_req !== 1'b1) begin n_fail++; $display("FAIL under_rd_pending: got %b expected 1", rd_req); end
        wait_clk(400);
        n_chk++;
        if ({rd_req, addr} !== {1'b0, 25'h400005}) begin
            n_fail++;
            $display("FAIL under_late_ack: got rd_req=%b addr=%h expected 0 400005", rd_req, addr);
        end
        ram_lat = 1;
    endtask

    task automatic test_discard();
        logic [7:0] rx;
        ram_auto = 1'b0;
        ss_low(); xfer(8'h57, 8, rx); ss_high();
        n_chk++;
        if ({rd_req, byte_cnt} !== {1'b1, 25'd5}) begin
            n_fail++;
            $display("FAIL disc_pending: got rd_req=%b byte_cnt=%0d expected 1 5", rd_req, byte_cnt);
        end
        ss_low(); xfer(8'h56, 8, rx); xfer(8'h00, 8, rx); ss_high();
        n_chk++;
        if ({uploading, rd_req} !== 2'b01) begin
            n_fail++;
            $display("FAIL stop_state: got uploading=%b rd_req=%b expected 0 1", uploading, rd_req);
        end
        m_din = 8'h11; m_ack = 1'b1; wait_clk(1); m_ack = 1'b0; wait_clk(2);
        n_chk++;
        if (rd_req !== 1'b0) begin n_fail++; $display("FAIL stop_ack_rd_req: got %b expected 0", rd_req); end
        ram_auto = 1'b1;
        ss_low(); xfer(8'h57, 8, rx); xfer(8'h00, 7, rx);
        n_chk++;
        if (sdo_oe !== 1'b0) begin n_fail++; $display("FAIL stopped_sdo_oe: got %b expected 0", sdo_oe); end
        ss_high();
        n_chk++;
        if (byte_cnt !== 25'd5) begin n_fail++; $display("FAIL stopped_byte_cnt: got %0d expected 5", byte_cnt); end
    endtask

    task automatic test_ss_abort();
        logic [7:0] rx;
        ss_low(); xfer(8'h56, 8, rx); xfer(8'h01, 8, rx); ss_high();
        ss_low(); xfer(8'h57, 8, rx); xfer(8'h00, 4, rx); ss_high();
        n_chk++;
        if ({byte_cnt, addr} !== {25'd1, 25'h400002}) begin
            n_fail++;
            $display("FAIL abort_state: got byte_cnt=%0d addr=%h expected 1 400002", byte_cnt, addr);
        end
        ss_low(); xfer(8'h57, 8, rx); xfer(8'h00, 7, rx); ss_high();
        n_chk++;
        if (rx !== 8'h5A) begin n_fail++; $display("FAIL abort_next_byte: got %h expected 5a", rx); end
        n_chk++;
        if ({byte_cnt, addr} !== {25'd2, 25'h400003}) begin
            n_fail++;
            $display("FAIL abort_no_rewind: got byte_cnt=%0d addr=%h expected 2 400003", byte_cnt, addr);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx;
        ram_auto = 1'b0;
        ss_low(); xfer(8'h57, 8, rx); ss_high();
        n_chk++;
        if (rd_req !== 1'b1) begin n_fail++; $display("FAIL pre_reset_rd_req: got %b expected 1", rd_req); end
        reset_n = 1'b0;
        #1;
        n_chk++;
        if ({rd_req, sdo, sdo_oe, uploading, underrun} !== 5'b0) begin
            n_fail++;
            $display("FAIL async_reset_flags: got %b expected 00000", {rd_req, sdo, sdo_oe, uploading, underrun});
        end
        n_chk++;
        if ({index, addr, byte_cnt} !== 55'd0) begin
            n_fail++;
            $display("FAIL async_reset_regs: got index=%h addr=%h byte_cnt=%h expected 0", index, addr, byte_cnt);
        end
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(2);
        m_din = 8'h77; m_ack = 1'b1; wait_clk(1); m_ack = 1'b0; wait_clk(2);
        n_chk++;
        if ({rd_req, uploading, addr} !== 27'd0) begin
            n_fail++;
            $display("FAIL late_ack: got rd_req=%b uploading=%b addr=%h expected 0 0 0", rd_req, uploading, addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        ram[0] = 8'hA5; ram[1] = 8'h5A; ram[2] = 8'h3C; ram[3] = 8'hC3; ram[4] = 8'h96;
        test_reset();
        test_index_start();
        test_data_read();
        test_underrun();
        test_discard();
        test_ss_abort();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
